receiver_axis: RTL

//  UART receiver: samples serial line din (8N1-style framing: 1 start bit, WORD_WIDTH data bits LSB first,
//  1 stop bit) and presents each received word on an AXI4-Stream master port. Counterpart of transmitter_axis;
//  a transmitter_axis dout wired to din forms a loopback path.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_sync.sv | 25 ++
 rtl/receiver_axis.sv | 133 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// UART shared types: line-state enum and bit-period helper.
// Used by receiver_axis and transmitter_axis; no logic of its own.
// No timing and no backpressure; declarations only.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  function automatic int unsigned cycles_per_bit(input int unsigned clock_frequency,
                                                 input int unsigned baud_rate);
    return clock_frequency / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Latency: 2 clk cycles from d to q.
// No backpressure; the output follows the input continuously.
module uart_sync #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/receiver_axis.sv
// UART receiver: 1 start, WORD_WIDTH data bits LSB first, 1 stop, word out on AXI4-Stream.
// Latency: tvalid rises 3 + HALF_CYCLES + (WORD_WIDTH+1)*BIT_CYCLES clk cycles after din falls.
// Backpressure: line is never stalled; a word finishing while one is still pending is dropped and overrun pulses.
module receiver_axis
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 32'd100_000_000,
  parameter int unsigned BAUD_RATE       = 32'd115200,
  parameter int unsigned WORD_WIDTH      = 32'd8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  din,
  output logic [WORD_WIDTH-1:0] dout_axis_tdata,
  output logic                  dout_axis_tvalid,
  input  logic                  dout_axis_tready,
  output logic                  frame_error,
  output logic                  overrun
);

  localparam int unsigned BIT_CYCLES  = cycles_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int unsigned HALF_CYCLES = BIT_CYCLES / 2;
  localparam int unsigned CNT_W       = $clog2(BIT_CYCLES + 1);
  localparam int unsigned IDX_W       = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WORD_WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  uart_state_t           state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [IDX_W-1:0]      bit_idx, bit_nxt;
  logic [WORD_WIDTH-1:0] shreg, shreg_nxt;
  logic [WORD_WIDTH-1:0] tdata_nxt;
  logic                  tvalid_nxt;
  logic                  fe_nxt;
  logic                  ov_nxt;
  logic                  din_s;
  logic                  din_s_d;

  uart_sync #(.RESET_VALUE(1'b1)) u_din_sync (
    .clk (clk),
    .rst (rst),
    .d   (din),
    .q   (din_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      bit_idx          <= '0;
      shreg            <= '0;
      din_s_d          <= 1'b1;
      dout_axis_tdata  <= '0;
      dout_axis_tvalid <= 1'b0;
      frame_error      <= 1'b0;
      overrun          <= 1'b0;
    end else begin
      state            <= state_nxt;
      cnt              <= cnt_nxt;
      bit_idx          <= bit_nxt;
      shreg            <= shreg_nxt;
      din_s_d          <= din_s;
      dout_axis_tdata  <= tdata_nxt;
      dout_axis_tvalid <= tvalid_nxt;
      frame_error      <= fe_nxt;
      overrun          <= ov_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    bit_nxt    = bit_idx;
    shreg_nxt  = shreg;
    tdata_nxt  = dout_axis_tdata;
    tvalid_nxt = dout_axis_tvalid;
    fe_nxt     = 1'b0;
    ov_nxt     = 1'b0;

    // An accept this cycle frees the holding register for a word landing on the same edge.
    if (dout_axis_tvalid && dout_axis_tready) tvalid_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (din_s_d && !din_s) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt   = '0;
          bit_nxt   = '0;
          state_nxt = din_s ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt            = '0;
          shreg_nxt[bit_idx] = din_s;
          if (bit_idx == IDX_LAST) state_nxt = STOP;
          else                     bit_nxt   = bit_idx + IDX_ONE;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
          if (!din_s) begin
            fe_nxt = 1'b1;
          end else if (tvalid_nxt) begin
            ov_nxt = 1'b1;
          end else begin
            tdata_nxt  = shreg;
            tvalid_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
